balance_seq: RTL and testbench
==============================

Name: balance_seq

Overview:
Power and soft-start sequencer for the Segway balance datapath. It turns the power button and load-cell readings into pwr_up, rider_off, en_steer and an 8-bit soft-start ramp ss_tmr for the balance controller. The ramp is driven down on faults or rider dismount, so the controller output fades out instead of stepping to zero. It sits between the sensor/button front end and the balance controller.

Parameters:
DIV, 4, clock cycles per ss_tmr step (ramp up or down); legal range 1..1023.
MIN_RIDER, 13'h0200, rider present when lft_ld+rght_ld > MIN_RIDER (unsigned, 13-bit sum).
DIFF_MAX, 12'h100, rider balanced when |lft_ld-rght_ld| < DIFF_MAX.
STEER_DLY, 32, consecutive balanced RUN cycles before en_steer asserts; legal range 1..1023.

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
pwr_btn  in  1  power button level, already debounced; a rising edge toggles power
lft_ld  in  12  left load cell, unsigned
rght_ld  in  12  right load cell, unsigned
batt_low  in  1  battery-low flag, level
too_fast  in  1  overspeed flag from balance controller, level
pwr_up  out  1  balance controller enable
rider_off  out  1  integrator clear request
en_steer  out  1  steering enable
ss_tmr  out  8  soft-start scale, unsigned, 0..255
state  out  3  OFF=0 IDLE=1 RAMP=2 RUN=3 STOP=4, for debug

Behaviour:
- Clock, reset and register timing:
  - Single clock domain. All outputs are registered.
  - Inputs are sampled at a clk edge; the resulting state and outputs are visible after that same edge.
  - rst=1 at a clk edge forces: state=OFF, pwr_up=0, rider_off=1, en_steer=0, ss_tmr=0, prescaler=0, steer counter=0, btn_q=0. This applies from any state, including mid-ramp.
- Button edge: btn_q is a registered copy of pwr_btn. btn_rise = pwr_btn & ~btn_q.
- Derived signals, combinational on the sampled inputs:
  - rider = ({1'b0,lft_ld}+{1'b0,rght_ld}) > MIN_RIDER.
  - bal = |lft_ld-rght_ld| < DIFF_MAX, computed 13-bit signed, no wrap.
  - fault = batt_low | too_fast.
- Prescaler:
  - Counts 0..DIV-1 in RAMP and STOP only. tick = (prescaler == DIV-1).
  - Cleared on every state change and in every other state.
- State machine (btn_rise takes priority over every other transition):
  - OFF: btn_rise -> IDLE.
  - Any state other than OFF: btn_rise -> OFF, with ss_tmr=0 immediately (hard power-off, no ramp down).
  - IDLE: rider & ~fault -> RAMP. Otherwise stay. ss_tmr is held at 0.
  - RAMP: ~rider | fault -> STOP, with ss_tmr held at its current value. Otherwise ss_tmr increments on tick. The tick that takes ss_tmr from 254 to 255 also moves the state to RUN.
  - RUN: ss_tmr=255. ~rider | fault -> STOP.
  - STOP: ss_tmr decrements on tick. The tick that takes ss_tmr from 1 to 0 moves the state to IDLE. If STOP is entered with ss_tmr=0, move to IDLE on the next cycle. Rider return and fault clear are ignored until IDLE is reached.
  - Encodings 5..7 are illegal and go to OFF on the next cycle.
- ss_tmr never wraps: it saturates at 255 and at 0.
- Output decode, registered with state:
  - pwr_up = 1 in IDLE, RAMP, RUN and STOP.
  - rider_off = 0 in RAMP and RUN; 1 in all other states.
  - state output equals the state register.
- Steering:
  - Steer counter (10 bits) increments each RUN cycle with bal=1 and saturates at STEER_DLY.
  - The counter clears when bal=0 or when the state is not RUN.
  - en_steer = 1 only while state==RUN and counter==STEER_DLY. It drops on the edge where bal=0 is sampled or RUN is left.
- Simultaneous events:
  - btn_rise together with fault or rider change: btn_rise wins.
  - fault and rider loss together in RAMP or RUN: a single transition to STOP.

Test Plan:
1. Reset mid-RAMP with ss_tmr=100, assert rst for 1 cycle -> after the edge: state=0, ss_tmr=0, pwr_up=0, rider_off=1, en_steer=0.
2. Power-up and ramp (DIV=4): pulse pwr_btn, then lft_ld=rght_ld=12'h300 -> IDLE, then RAMP the next cycle. ss_tmr increments every 4 cycles and reaches 255 exactly 1020 cycles after entering RAMP, with state=RUN on that same edge. rider_off=0 throughout RAMP and RUN.
3. Steer enable (STEER_DLY=32): in RUN with balanced loads -> en_steer rises after 32 RUN cycles. Set lft_ld=12'h500, rght_ld=12'h100 -> en_steer=0 on the next edge. Rebalance -> en_steer reasserts after another 32 cycles.
4. Fault ramp-down: in RUN assert too_fast for 1 cycle -> STOP, ss_tmr decrements 255->0 over 1020 cycles, then IDLE. Deasserting too_fast and keeping the rider on during STOP does not abort the ramp-down. IDLE then re-enters RAMP.
5. Hard off: in RAMP with ss_tmr=40, rising pwr_btn edge -> OFF with ss_tmr=0 and pwr_up=0 on that edge. Holding pwr_btn high does not re-toggle power.
6. batt_low with rider present in IDLE -> stay in IDLE with ss_tmr=0. Clearing batt_low -> RAMP on the next edge.

Source files
------------

// File: rtl/balance_seq_if.sv
// Sensor/button inputs and sequencer outputs of balance_seq, bundled as one port.
interface balance_seq_if;
  logic        pwr_btn;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic        batt_low;
  logic        too_fast;
  logic        pwr_up;
  logic        rider_off;
  logic        en_steer;
  logic [7:0]  ss_tmr;
  logic [2:0]  state;

  // Front end / testbench side: drives inputs, observes sequencer outputs
  modport master (
    output pwr_btn, lft_ld, rght_ld, batt_low, too_fast,
    input  pwr_up, rider_off, en_steer, ss_tmr, state
  );

  // Sequencer side
  modport slave (
    input  pwr_btn, lft_ld, rght_ld, batt_low, too_fast,
    output pwr_up, rider_off, en_steer, ss_tmr, state
  );
endinterface

// File: rtl/balance_seq.sv
// Power and soft-start sequencer for the balance datapath. Produces the
// controller enable, integrator clear, steering enable and an 8-bit ramp
// that fades the controller in on mount and out on fault or dismount.
module balance_seq #(
  parameter int unsigned DIV       = 4,
  parameter logic [12:0] MIN_RIDER = 13'h0200,
  parameter logic [11:0] DIFF_MAX  = 12'h100,
  parameter int unsigned STEER_DLY = 32
) (
  input logic         clk,
  input logic         rst,
  balance_seq_if.slave bus
);

  typedef enum logic [2:0] {
    StOff  = 3'd0,
    StIdle = 3'd1,
    StRamp = 3'd2,
    StRun  = 3'd3,
    StStop = 3'd4
  } state_e;

  localparam logic [9:0] DivLast  = 10'(DIV - 1);
  localparam logic [9:0] SteerMax = 10'(STEER_DLY);

  state_e      state_q, state_d;
  logic [7:0]  ss_q, ss_d;
  logic [9:0]  presc_q, presc_d;
  logic [9:0]  steer_q, steer_d;
  logic        btn_q;
  logic        pwr_up_q, pwr_up_d;
  logic        rider_off_q, rider_off_d;
  logic        en_steer_q, en_steer_d;

  logic               btn_rise;
  logic               rider;
  logic               bal;
  logic               fault;
  logic               tick;
  logic [12:0]        ld_sum;
  logic signed [12:0] ld_diff;
  logic [12:0]        ld_abs;

  assign btn_rise = bus.pwr_btn & ~btn_q;
  assign fault    = bus.batt_low | bus.too_fast;
  assign ld_sum   = {1'b0, bus.lft_ld} + {1'b0, bus.rght_ld};
  assign ld_diff  = signed'({1'b0, bus.lft_ld}) - signed'({1'b0, bus.rght_ld});
  // 13-bit signed difference cannot overflow, so the magnitude is exact
  assign ld_abs   = ld_diff[12] ? unsigned'(-ld_diff) : unsigned'(ld_diff);
  assign rider    = ld_sum > MIN_RIDER;
  assign bal      = ld_abs < {1'b0, DIFF_MAX};
  assign tick     = (presc_q == DivLast);

  // Next state and soft-start ramp; a button edge outranks everything else
  always_comb begin
    state_d = state_q;
    ss_d    = ss_q;
    if (btn_rise && (state_q != StOff)) begin
      // Hard power-off: no ramp down
      state_d = StOff;
      ss_d    = 8'd0;
    end else begin
      case (state_q)
        StOff: begin
          ss_d = 8'd0;
          if (btn_rise) state_d = StIdle;
        end
        StIdle: begin
          ss_d = 8'd0;
          if (rider && !fault) state_d = StRamp;
        end
        StRamp: begin
          if (!rider || fault) begin
            state_d = StStop;
          end else if (ss_q == 8'hff) begin
            state_d = StRun;
          end else if (tick) begin
            ss_d = ss_q + 8'd1;
            if (ss_q == 8'hfe) state_d = StRun;
          end
        end
        StRun: begin
          ss_d = 8'hff;
          if (!rider || fault) state_d = StStop;
        end
        StStop: begin
          // Rider return and fault clear are ignored until IDLE
          if (ss_q == 8'd0) begin
            state_d = StIdle;
          end else if (tick) begin
            ss_d = ss_q - 8'd1;
            if (ss_q == 8'd1) state_d = StIdle;
          end
        end
        default: begin
          state_d = StOff;
          ss_d    = 8'd0;
        end
      endcase
    end
  end

  // Prescaler, steering counter and registered output decode
  always_comb begin
    presc_d = 10'd0;
    if ((state_d == state_q) && ((state_q == StRamp) || (state_q == StStop)) && !tick) begin
      presc_d = presc_q + 10'd1;
    end

    steer_d = 10'd0;
    if ((state_q == StRun) && bal) begin
      steer_d = (steer_q == SteerMax) ? steer_q : steer_q + 10'd1;
    end

    pwr_up_d    = (state_d != StOff);
    rider_off_d = !((state_d == StRamp) || (state_d == StRun));
    en_steer_d  = (state_d == StRun) && (steer_d == SteerMax);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StOff;
      ss_q        <= 8'd0;
      presc_q     <= 10'd0;
      steer_q     <= 10'd0;
      btn_q       <= 1'b0;
      pwr_up_q    <= 1'b0;
      rider_off_q <= 1'b1;
      en_steer_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ss_q        <= ss_d;
      presc_q     <= presc_d;
      steer_q     <= steer_d;
      btn_q       <= bus.pwr_btn;
      pwr_up_q    <= pwr_up_d;
      rider_off_q <= rider_off_d;
      en_steer_q  <= en_steer_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.ss_tmr    = ss_q;
  assign bus.pwr_up    = pwr_up_q;
  assign bus.rider_off = rider_off_q;
  assign bus.en_steer  = en_steer_q;

endmodule

// File: tb/tb_balance_seq.sv
// Directed bench for balance_seq: each step pushes the expected output
// vector, advances the clock, then pops and compares against the DUT.
module tb_balance_seq;

  localparam logic [2:0] S_OFF  = 3'd0;
  localparam logic [2:0] S_IDLE = 3'd1;
  localparam logic [2:0] S_RAMP = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_STOP = 3'd4;

  typedef struct {
    string       tag;
    logic [13:0] vec;  // {state, ss_tmr, pwr_up, rider_off, en_steer}
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  balance_seq_if bus ();

  balance_seq #(
    .DIV      (4),
    .MIN_RIDER(13'h0200),
    .DIFF_MAX (12'h100),
    .STEER_DLY(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Queue the expectation, advance n edges, sample 1 time unit after the edge
  task automatic run(input int n, input string tag, input logic [2:0] st, input logic [7:0] ss,
                     input logic pu, input logic ro, input logic es);
    exp_t        e;
    exp_t        h;
    logic [13:0] obs;
    e.tag = tag;
    e.vec = {st, ss, pu, ro, es};
    sb.push_back(e);
    repeat (n) @(posedge clk);
    #1;
    h   = sb.pop_front();
    obs = {bus.state, bus.ss_tmr, bus.pwr_up, bus.rider_off, bus.en_steer};
    checks++;
    assert (obs === h.vec) else begin
      errors++;
      $error("FAIL %s: got state=%0d ss=%0d pu=%b ro=%b es=%b, expected state=%0d ss=%0d pu=%b ro=%b es=%b",
             h.tag, obs[13:11], obs[10:3], obs[2], obs[1], obs[0],
             h.vec[13:11], h.vec[10:3], h.vec[2], h.vec[1], h.vec[0]);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.pwr_btn  = 1'b0;
    bus.lft_ld   = 12'h000;
    bus.rght_ld  = 12'h000;
    bus.batt_low = 1'b0;
    bus.too_fast = 1'b0;
    run(2, "reset", S_OFF, 8'd0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    run(1, "off idle", S_OFF, 8'd0, 1'b0, 1'b1, 1'b0);

    // Power-up and ramp
    bus.pwr_btn = 1'b1;
    bus.lft_ld  = 12'h300;
    bus.rght_ld = 12'h300;
    run(1, "pwr to idle", S_IDLE, 8'd0, 1'b1, 1'b1, 1'b0);
    bus.pwr_btn = 1'b0;
    run(1, "enter ramp", S_RAMP, 8'd0, 1'b1, 1'b0, 1'b0);
    run(3, "ramp pre tick", S_RAMP, 8'd0, 1'b1, 1'b0, 1'b0);
    run(1, "ramp first tick", S_RAMP, 8'd1, 1'b1, 1'b0, 1'b0);
    for (int k = 2; k <= 254; k++) begin
      run(4, $sformatf("ramp k=%0d", k), S_RAMP, 8'(k), 1'b1, 1'b0, 1'b0);
    end
    run(3, "ramp hold 254", S_RAMP, 8'd254, 1'b1, 1'b0, 1'b0);
    run(1, "ramp to run", S_RUN, 8'd255, 1'b1, 1'b0, 1'b0);

    // Steering enable
    run(31, "steer not yet", S_RUN, 8'd255, 1'b1, 1'b0, 1'b0);
    run(1, "steer on", S_RUN, 8'd255, 1'b1, 1'b0, 1'b1);
    bus.lft_ld  = 12'h500;
    bus.rght_ld = 12'h100;
    run(1, "steer drop", S_RUN, 8'd255, 1'b1, 1'b0, 1'b0);
    bus.lft_ld  = 12'h300;
    bus.rght_ld = 12'h300;
    run(31, "steer rewait", S_RUN, 8'd255, 1'b1, 1'b0, 1'b0);
    run(1, "steer reon", S_RUN, 8'd255, 1'b1, 1'b0, 1'b1);

    // Fault ramp-down; rider stays on and fault clears, ramp-down continues
    bus.too_fast = 1'b1;
    run(1, "fault to stop", S_STOP, 8'd255, 1'b1, 1'b1, 1'b0);
    bus.too_fast = 1'b0;
    for (int k = 1; k <= 254; k++) begin
      run(4, $sformatf("stop k=%0d", k), S_STOP, 8'(255 - k), 1'b1, 1'b1, 1'b0);
    end
    run(3, "stop hold 1", S_STOP, 8'd1, 1'b1, 1'b1, 1'b0);
    run(1, "stop to idle", S_IDLE, 8'd0, 1'b1, 1'b1, 1'b0);
    run(1, "idle reramp", S_RAMP, 8'd0, 1'b1, 1'b0, 1'b0);

    // Hard off mid-ramp
    run(160, "ramp at 40", S_RAMP, 8'd40, 1'b1, 1'b0, 1'b0);
    bus.pwr_btn = 1'b1;
    run(1, "hard off", S_OFF, 8'd0, 1'b0, 1'b1, 1'b0);
    run(3, "btn held", S_OFF, 8'd0, 1'b0, 1'b1, 1'b0);
    bus.pwr_btn = 1'b0;
    run(1, "btn released", S_OFF, 8'd0, 1'b0, 1'b1, 1'b0);

    // Battery low blocks ramp from IDLE
    bus.batt_low = 1'b1;
    bus.pwr_btn  = 1'b1;
    run(1, "batt pwr idle", S_IDLE, 8'd0, 1'b1, 1'b1, 1'b0);
    bus.pwr_btn = 1'b0;
    run(3, "batt hold idle", S_IDLE, 8'd0, 1'b1, 1'b1, 1'b0);
    bus.batt_low = 1'b0;
    run(1, "batt clear ramp", S_RAMP, 8'd0, 1'b1, 1'b0, 1'b0);

    // Reset mid-ramp
    run(400, "ramp at 100", S_RAMP, 8'd100, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    run(1, "reset mid ramp", S_OFF, 8'd0, 1'b0, 1'b1, 1'b0);
    rst = 1'b0;
    run(2, "off after reset", S_OFF, 8'd0, 1'b0, 1'b1, 1'b0);

    // Fault plus rider loss together; STOP entered at zero exits next cycle
    bus.pwr_btn = 1'b1;
    run(1, "repower idle", S_IDLE, 8'd0, 1'b1, 1'b1, 1'b0);
    bus.pwr_btn = 1'b0;
    run(1, "repower ramp", S_RAMP, 8'd0, 1'b1, 1'b0, 1'b0);
    bus.too_fast = 1'b1;
    bus.lft_ld   = 12'h000;
    bus.rght_ld  = 12'h000;
    run(1, "dual to stop", S_STOP, 8'd0, 1'b1, 1'b1, 1'b0);
    run(1, "stop zero idle", S_IDLE, 8'd0, 1'b1, 1'b1, 1'b0);
    run(1, "idle fault hold", S_IDLE, 8'd0, 1'b1, 1'b1, 1'b0);
    bus.too_fast = 1'b0;
    bus.lft_ld   = 12'h300;
    bus.rght_ld  = 12'h300;
    run(1, "idle to ramp", S_RAMP, 8'd0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
